// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared encodings for the bit-serial add/subtract sequencer.
package serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_fa_cell.sv
// One-bit full adder built from two-input gate primitives.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ab_x;
  logic ab_a;
  logic xc_a;

  xor u_x0 (ab_x, a, b);
  xor u_x1 (s, ab_x, ci);
  and u_a0 (ab_a, a, b);
  and u_a1 (xc_a, ab_x, ci);
  or  u_o0 (co, ab_a, xc_a);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one shared full adder, LSB first,
// WIDTH cycles per operation, registered result/carry/overflow with done pulse.
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ov
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             sum_bit;
  logic             carry_next;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (sum_bit),
    .co (carry_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_EXEC;
      ST_EXEC: if (last_bit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      co     <= 1'b0;
      ov     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
            a_sr  <= a;
            b_sr  <= (op == OP_SUB) ? ~b : b;
            carry <= op;
            cnt   <= '0;
          end
        end
        ST_EXEC: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          result <= {sum_bit, result[WIDTH-1:1]};
          carry  <= carry_next;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            // carry still holds the carry into the MSB at this point.
            done <= 1'b1;
            co   <= carry_next;
            ov   <= carry ^ carry_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_addsub_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start, op;
  logic [7:0] a, b;
  logic       busy, done, co, ov;
  logic [7:0] result;
  logic       start2, op2;
  logic [1:0] a2, b2, result2;
  logic       busy2, done2, co2, ov2;

  int checks;
  int failures;

  int         r_lat, r_busy;
  logic       r_to, r_co, r_ov, r_after_done, r_after_busy;
  logic [7:0] r_res;

  serial_addsub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .co(co), .ov(ov)
  );

  serial_addsub_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .op(op2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(result2), .co(co2), .ov(ov2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation; r_lat counts clocks from the accepting edge (inclusive)
  // to the edge after which done is first seen.
  task automatic do_op(input bit w2, input logic [7:0] av, input logic [7:0] bv, input logic opv);
    @(negedge clk);
    if (w2) begin
      a2 = av[1:0]; b2 = bv[1:0]; op2 = opv; start2 = 1'b1;
    end else begin
      a = av; b = bv; op = opv; start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
    r_lat = 1; r_busy = 0; r_to = 1'b1;
    r_res = '0; r_co = 1'b0; r_ov = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (w2 ? busy2 : busy) r_busy++;
      if (w2 ? done2 : done) begin
        r_to  = 1'b0;
        r_res = w2 ? {6'b0, result2} : result;
        r_co  = w2 ? co2 : co;
        r_ov  = w2 ? ov2 : ov;
        break;
      end
      @(posedge clk); #1;
      r_lat++;
    end
    @(posedge clk); #1;
    r_after_done = w2 ? done2 : done;
    r_after_busy = w2 ? busy2 : busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 0; op = 0; a = '0; b = '0;
    start2 = 0; op2 = 0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result, co, ov} !== 12'h000) begin
      failures++;
      $display("FAIL reset_w8 got busy=%b done=%b result=%h co=%b ov=%b expected all 0", busy, done, result, co, ov);
    end
    checks++;
    if ({busy2, done2, result2, co2, ov2} !== 6'h00) begin
      failures++;
      $display("FAIL reset_w2 got busy=%b done=%b result=%h co=%b ov=%b expected all 0", busy2, done2, result2, co2, ov2);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_add();
    logic [7:0] va [4] = '{8'h3C, 8'h7F, 8'hFF, 8'h10};
    logic [7:0] vb [4] = '{8'h15, 8'h01, 8'h01, 8'h20};
    logic [7:0] er [4] = '{8'h51, 8'h80, 8'h00, 8'h30};
    logic       ec [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       eo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      do_op(1'b0, va[k], vb[k], 1'b0);
      checks++;
      if (r_to !== 1'b0 || r_lat != 9) begin
        failures++;
        $display("FAIL add_latency %h+%h got timeout=%b lat=%0d expected lat=9", va[k], vb[k], r_to, r_lat);
      end
      checks++;
      if (r_res !== er[k] || r_co !== ec[k] || r_ov !== eo[k]) begin
        failures++;
        $display("FAIL add_value %h+%h got result=%h co=%b ov=%b expected result=%h co=%b ov=%b",
                 va[k], vb[k], r_res, r_co, r_ov, er[k], ec[k], eo[k]);
      end
      checks++;
      if (r_busy != 9 || r_after_done !== 1'b0 || r_after_busy !== 1'b0) begin
        failures++;
        $display("FAIL add_busy %h+%h got busy_cycles=%0d done_after=%b busy_after=%b expected 9 0 0",
                 va[k], vb[k], r_busy, r_after_done, r_after_busy);
      end
      $display("add %h+%h -> result=%h co=%b ov=%b lat=%0d", va[k], vb[k], r_res, r_co, r_ov, r_lat);
    end
  endtask

  task automatic test_sub();
    logic [7:0] va [3] = '{8'h05, 8'h80, 8'h20};
    logic [7:0] vb [3] = '{8'h07, 8'h01, 8'h20};
    logic [7:0] er [3] = '{8'hFE, 8'h7F, 8'h00};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};
    logic       eo [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      do_op(1'b0, va[k], vb[k], 1'b1);
      checks++;
      if (r_to !== 1'b0 || r_res !== er[k] || r_co !== ec[k] || r_ov !== eo[k] || r_lat != 9) begin
        failures++;
        $display("FAIL sub_value %h-%h got result=%h co=%b ov=%b lat=%0d timeout=%b expected result=%h co=%b ov=%b lat=9",
                 va[k], vb[k], r_res, r_co, r_ov, r_lat, r_to, er[k], ec[k], eo[k]);
      end
      $display("sub %h-%h -> result=%h co=%b ov=%b lat=%0d", va[k], vb[k], r_res, r_co, r_ov, r_lat);
    end
  endtask

  task automatic test_ignore_start();
    int n_done, first_lat, lat, busy_cnt;
    logic [7:0] first_res;
    n_done = 0; first_lat = 0; busy_cnt = 0; first_res = '0;
    @(negedge clk);
    a = 8'h10; b = 8'h20; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    for (int i = 0; i < 30; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          first_lat = lat;
          first_res = result;
        end
      end
      // Pulses land on an EXEC edge and on the DONE-cycle edge respectively.
      if (lat == 3) begin
        a = 8'hFF; b = 8'hFF; start = 1'b1;
      end else if (done && n_done == 1) begin
        a = 8'h01; b = 8'h01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++;
    if (n_done != 1 || first_lat != 9) begin
      failures++;
      $display("FAIL ignore_done got dones=%0d first_lat=%0d expected 1 and 9", n_done, first_lat);
    end
    checks++;
    if (first_res !== 8'h30 || result !== 8'h30) begin
      failures++;
      $display("FAIL ignore_result got at_done=%h later=%h expected 30", first_res, result);
    end
    checks++;
    if (busy_cnt != 9) begin
      failures++;
      $display("FAIL ignore_busy got busy_cycles=%0d expected 9", busy_cnt);
    end
    $display("ignore_start dones=%0d result=%h busy_cycles=%0d", n_done, result, busy_cnt);
    do_op(1'b0, 8'h22, 8'h11, 1'b0);
    checks++;
    if (r_to !== 1'b0 || r_res !== 8'h33 || r_lat != 9) begin
      failures++;
      $display("FAIL after_ignore got result=%h lat=%0d timeout=%b expected 33 lat=9", r_res, r_lat, r_to);
    end
  endtask

  task automatic test_async_reset();
    do_op(1'b0, 8'h80, 8'h01, 1'b1);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, co, ov} !== 12'h000) begin
      failures++;
      $display("FAIL async_reset got busy=%b done=%b result=%h co=%b ov=%b expected all 0", busy, done, result, co, ov);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
      failures++;
      $display("FAIL async_discard got busy=%b done=%b result=%h expected 0 0 00", busy, done, result);
    end
    do_op(1'b0, 8'h01, 8'h02, 1'b0);
    checks++;
    if (r_to !== 1'b0 || r_res !== 8'h03 || r_co !== 1'b0 || r_ov !== 1'b0 || r_lat != 9) begin
      failures++;
      $display("FAIL post_reset_op got result=%h co=%b ov=%b lat=%0d timeout=%b expected 03 0 0 lat=9",
               r_res, r_co, r_ov, r_lat, r_to);
    end
    $display("async_reset then 01+02 -> result=%h lat=%0d", r_res, r_lat);
  endtask

  task automatic test_width2();
    logic [1:0] va [3] = '{2'd2, 2'd1, 2'd3};
    logic [1:0] vb [3] = '{2'd3, 2'd1, 2'd3};
    logic [1:0] er [3] = '{2'd1, 2'd2, 2'd2};
    logic       ec [3] = '{1'b1, 1'b0, 1'b1};
    logic       eo [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      do_op(1'b1, {6'b0, va[k]}, {6'b0, vb[k]}, 1'b0);
      checks++;
      if (r_to !== 1'b0 || r_res[1:0] !== er[k] || r_co !== ec[k] || r_ov !== eo[k] || r_lat != 3) begin
        failures++;
        $display("FAIL w2_add %0d+%0d got result=%0d co=%b ov=%b lat=%0d timeout=%b expected result=%0d co=%b ov=%b lat=3",
                 va[k], vb[k], r_res[1:0], r_co, r_ov, r_lat, r_to, er[k], ec[k], eo[k]);
      end
      checks++;
      if (r_busy != 3 || r_after_done !== 1'b0) begin
        failures++;
        $display("FAIL w2_busy got busy_cycles=%0d done_after=%b expected 3 0", r_busy, r_after_done);
      end
      $display("w2 add %0d+%0d -> result=%0d co=%b ov=%b lat=%0d", va[k], vb[k], r_res[1:0], r_co, r_ov, r_lat);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_async_reset();
    test_width2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
